// File: rtl/vga_pkg.sv
// Types and widths shared by the VGA text-mode blocks (readout, host_interface,
// vram_arbiter).
package vga_pkg;

    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_DISP,
        GRANT_HOST
    } grant_e;

    typedef struct packed {
        logic                   wr;
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
    } host_req_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Display, host and RAM-side signals of the VRAM arbiter. The arbiter takes the
// slave view; display, host and RAM models take the master view.
interface vram_arbiter_if
    import vga_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) ();

    logic              dispReq;
    logic [ADDR_W-1:0] dispAddr;
    logic              dispRdValid;
    logic              hostReq;
    logic              hostWr;
    logic [ADDR_W-1:0] hostAddr;
    logic [DATA_W-1:0] hostWrData;
    logic              hostReady;
    logic              hostRdValid;
    logic [DATA_W-1:0] hostRdData;
    logic [ADDR_W-1:0] ramAddr;
    logic [DATA_W-1:0] ramWrData;
    logic              ramWe;
    logic [DATA_W-1:0] ramRdData;
    logic              starve;

    modport slave (
        input  dispReq, dispAddr, hostReq, hostWr, hostAddr, hostWrData, ramRdData,
        output dispRdValid, hostReady, hostRdValid, hostRdData,
               ramAddr, ramWrData, ramWe, starve
    );

    modport master (
        output dispReq, dispAddr, hostReq, hostWr, hostAddr, hostWrData, ramRdData,
        input  dispRdValid, hostReady, hostRdValid, hostRdData,
               ramAddr, ramWrData, ramWe, starve
    );

endinterface

// File: rtl/vram_arbiter_fifo.sv
// Synchronous request queue for host VRAM accesses; pointers wrap modulo DEPTH.
module host_req_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full queue refuses pushes even when a pop frees a slot this cycle.
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads always win, queued host accesses fill
// idle cycles, and read returns are tagged so each requester sees its own data.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int DATA_W       = VRAM_DATA_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 800
) (
    input  logic          clk,
    input  logic          nrst,
    vram_arbiter_if.slave bus
);
    localparam int REQ_W    = 1 + ADDR_W + DATA_W;
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    grant_e              grant;
    logic                running;
    logic                host_ready;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [REQ_W-1:0]    head;
    logic                head_wr;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;
    logic [ADDR_W-1:0]   ram_addr_p1;
    logic [DATA_W-1:0]   ram_wr_data_p1;
    logic                ram_we_p1;
    logic                disp_tag_p1;
    logic                host_tag_p1;
    logic                disp_tag_p2;
    logic                host_tag_p2;
    logic [DATA_W-1:0]   host_rd_data_p3;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_cnt_next;
    logic                starve_q;

    // hostReady is held low during reset and rises one cycle after release.
    assign host_ready = running && !fifo_full;
    assign push       = bus.hostReq && host_ready;
    assign pop        = (grant == GRANT_HOST);
    assign head_wr    = head[REQ_W-1];
    assign head_addr  = head[DATA_W +: ADDR_W];
    assign head_data  = head[DATA_W-1:0];

    host_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.hostWr, bus.hostAddr, bus.hostWrData}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        grant = GRANT_NONE;
        if (bus.dispReq)  grant = GRANT_DISP;
        else if (!fifo_empty) grant = GRANT_HOST;
    end

    always_comb begin
        starve_cnt_next = starve_cnt;
        if (pop) begin
            starve_cnt_next = '0;
        end else if ((fifo_count != '0) && (starve_cnt != STARVE_MAX)) begin
            starve_cnt_next = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            running         <= 1'b0;
            ram_addr_p1     <= '0;
            ram_wr_data_p1  <= '0;
            ram_we_p1       <= 1'b0;
            disp_tag_p1     <= 1'b0;
            host_tag_p1     <= 1'b0;
            disp_tag_p2     <= 1'b0;
            host_tag_p2     <= 1'b0;
            host_rd_data_p3 <= '0;
            starve_cnt      <= '0;
            starve_q        <= 1'b0;
        end else begin
            running <= 1'b1;

            // Stage p1: registered RAM command; address holds when nothing is granted.
            ram_we_p1   <= 1'b0;
            disp_tag_p1 <= (grant == GRANT_DISP);
            host_tag_p1 <= pop && !head_wr;
            case (grant)
                GRANT_DISP: ram_addr_p1 <= bus.dispAddr;
                GRANT_HOST: begin
                    ram_addr_p1    <= head_addr;
                    ram_wr_data_p1 <= head_data;
                    ram_we_p1      <= head_wr;
                end
                default: ;
            endcase

            // Stage p2: tags line up with ramRdData returned by the RAM.
            disp_tag_p2 <= disp_tag_p1;
            host_tag_p2 <= host_tag_p1;

            // Stage p3: host read data captured and held until the next host read.
            if (host_tag_p2) host_rd_data_p3 <= bus.ramRdData;

            starve_cnt <= starve_cnt_next;
            starve_q   <= starve_q | (starve_cnt_next == STARVE_MAX);
        end
    end

    assign bus.hostReady   = host_ready;
    assign bus.ramAddr     = ram_addr_p1;
    assign bus.ramWrData   = ram_wr_data_p1;
    assign bus.ramWe       = ram_we_p1;
    assign bus.dispRdValid = disp_tag_p2;
    assign bus.hostRdValid = host_tag_p2;
    assign bus.hostRdData  = host_rd_data_p3;
    assign bus.starve      = starve_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a registered-read RAM model and a
// queue of expected host read data.
module tb_vram_arbiter;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] model_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic              disp_d1;
    logic              disp_d2;
    logic              rd_chk_next = 1'b0;
    logic [DATA_W-1:0] rd_held = '0;

    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vram_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (800)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    // Single-port RAM: write and registered read on the same edge.
    always @(posedge clk) begin
        if (bus.ramWe) ram[bus.ramAddr] <= bus.ramWrData;
        bus.ramRdData <= ram[bus.ramAddr];
    end

    // Display return is expected exactly two cycles after the request.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            disp_d1 <= 1'b0;
            disp_d2 <= 1'b0;
        end else begin
            disp_d1 <= bus.dispReq;
            disp_d2 <= disp_d1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dispReq = 1'b0;
        bus.hostReq = 1'b0;
    endtask

    task automatic drive_host(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        bus.hostReq    = 1'b1;
        bus.hostWr     = wr;
        bus.hostAddr   = addr;
        bus.hostWrData = data;
    endtask

    // Output monitor: display valid timing and host read scoreboard.
    always begin
        @(posedge clk);
        #1;
        check("disp_rd_valid", 32'(bus.dispRdValid), 32'(disp_d2));
        if (rd_chk_next && nrst) check("host_rd_data_hold", 32'(bus.hostRdData), 32'(rd_held));
        rd_chk_next = 1'b0;
        if (bus.hostRdValid) begin
            check("host_rd_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                rd_held = exp_q.pop_front();
                check("host_rd_ram_data", 32'(bus.ramRdData), 32'(rd_held));
                rd_chk_next = 1'b1;
            end
        end
    end

    initial begin
        bus.dispReq    = 1'b0;
        bus.dispAddr   = '0;
        bus.hostReq    = 1'b0;
        bus.hostWr     = 1'b0;
        bus.hostAddr   = '0;
        bus.hostWrData = '0;
        nrst = 1'b0;

        // Reset held with random inputs: every output stays zero.
        for (int i = 0; i < 6; i++) begin
            bus.dispReq    = 1'($urandom);
            bus.dispAddr   = 13'($urandom);
            bus.hostReq    = 1'($urandom);
            bus.hostWr     = 1'($urandom);
            bus.hostAddr   = 13'($urandom);
            bus.hostWrData = 8'($urandom);
            tick();
            check("reset_outputs_zero", 32'({bus.ramAddr, bus.ramWrData, bus.ramWe, bus.dispRdValid,
                  bus.hostRdValid, bus.hostRdData, bus.hostReady, bus.starve} != '0), 32'd0);
        end
        idle();
        #2 nrst = 1'b1;
        tick();
        check("ready_after_reset", 32'(bus.hostReady), 32'd1);
        check("no_valid_after_reset", 32'({bus.dispRdValid, bus.hostRdValid}), 32'd0);

        // Host write then read of the same address.
        drive_host(1'b1, 13'h0123, 8'hA5);
        model_mem[13'h0123] = 8'hA5;
        tick();
        drive_host(1'b0, 13'h0123, 8'h00);
        exp_q.push_back(model_mem[13'h0123]);
        check("wr_we_not_yet", 32'(bus.ramWe), 32'd0);
        tick();
        bus.hostReq = 1'b0;
        check("wr_we_c2", 32'(bus.ramWe), 32'd1);
        check("wr_addr_c2", 32'(bus.ramAddr), 32'h0123);
        check("wr_data_c2", 32'(bus.ramWrData), 32'hA5);
        tick();
        check("wr_we_one_cycle", 32'(bus.ramWe), 32'd0);
        tick();
        check("rd_valid_c4", 32'(bus.hostRdValid), 32'd1);
        check("rd_ram_data_c4", 32'(bus.ramRdData), 32'hA5);
        tick();
        check("rd_data_c5", 32'(bus.hostRdData), 32'hA5);
        check("rd_valid_pulse", 32'(bus.hostRdValid), 32'd0);
        for (int i = 0; i < 3; i++) tick();

        // Display priority: 80 cycles of display reads with 4 host writes queued.
        bus.dispReq = 1'b1;
        for (int c = 0; c < 80; c++) begin
            bus.dispAddr = 13'(c * 3);
            if (c < 4) begin
                check("prio_ready", 32'(bus.hostReady), 32'd1);
                drive_host(1'b1, 13'(32'h200 + c), 8'(32'h10 + c));
                model_mem[13'(32'h200 + c)] = 8'(32'h10 + c);
            end else begin
                bus.hostReq = 1'b0;
            end
            if (c == 4) check("prio_full_ready", 32'(bus.hostReady), 32'd0);
            check("prio_no_we", 32'(bus.ramWe), 32'd0);
            tick();
        end
        bus.dispReq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("prio_drain_we", 32'(bus.ramWe), 32'd1);
            check("prio_drain_addr", 32'(bus.ramAddr), 32'h200 + i);
            check("prio_drain_data", 32'(bus.ramWrData), 32'h10 + i);
        end
        tick();
        check("prio_drain_done", 32'(bus.ramWe), 32'd0);

        // Full boundary: a request offered while full is refused even as a pop happens.
        drive_host(1'b1, 13'h03FF, 8'h77);
        model_mem[13'h03FF] = 8'h77;
        tick();
        bus.hostReq = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.dispReq = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive_host(1'b1, 13'(32'h300 + c), 8'(32'h20 + c));
            model_mem[13'(32'h300 + c)] = 8'(32'h20 + c);
            tick();
        end
        check("full_ready_low", 32'(bus.hostReady), 32'd0);
        bus.dispReq = 1'b0;
        drive_host(1'b1, 13'h03FF, 8'hEE);
        tick();
        bus.hostReq = 1'b0;
        check("full_ready_rises", 32'(bus.hostReady), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("full_drain_we", 32'(bus.ramWe), 32'd1);
            check("full_drain_addr", 32'(bus.ramAddr), 32'h300 + i);
            tick();
        end
        check("full_no_extra_we", 32'(bus.ramWe), 32'd0);
        drive_host(1'b0, 13'h03FF, 8'h00);
        exp_q.push_back(model_mem[13'h03FF]);
        tick();
        bus.hostReq = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Starvation: one host read blocked by continuous display reads.
        check("starve_clear_before", 32'(bus.starve), 32'd0);
        bus.dispReq = 1'b1;
        drive_host(1'b0, 13'h0123, 8'h00);
        exp_q.push_back(model_mem[13'h0123]);
        tick();
        bus.hostReq = 1'b0;
        for (int c = 1; c < 800; c++) begin
            bus.dispAddr = 13'($urandom);
            tick();
        end
        check("starve_before_limit", 32'(bus.starve), 32'd0);
        tick();
        check("starve_at_limit", 32'(bus.starve), 32'd1);
        bus.dispReq = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("starve_sticky", 32'(bus.starve), 32'd1);
        check("starve_read_returned", 32'(exp_q.size()), 32'd0);
        #2 nrst = 1'b0;
        tick();
        check("starve_reset", 32'(bus.starve), 32'd0);
        #2 nrst = 1'b1;
        tick();

        // Reset one cycle after a host read pops, with a write still queued.
        drive_host(1'b0, 13'h0200, 8'h00);
        exp_q.push_back(model_mem[13'h0200]);
        tick();
        drive_host(1'b1, 13'h0555, 8'h99);
        tick();
        bus.hostReq = 1'b0;
        #2 nrst = 1'b0;
        exp_q.delete();
        tick();
        check("midrd_reset_valid", 32'(bus.hostRdValid), 32'd0);
        #2 nrst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrd_no_valid", 32'(bus.hostRdValid), 32'd0);
            check("midrd_no_we", 32'(bus.ramWe), 32'd0);
            check("midrd_addr_idle", 32'(bus.ramAddr), 32'd0);
            check("midrd_ready", 32'(bus.hostReady), 32'd1);
        end

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one single-port VRAM between the display readout path and the host interface. The display path has absolute priority and a fixed read latency. Host reads and writes are queued in a small FIFO and issued in otherwise idle cycles, such as horizontal/vertical blanking and gaps between character fetches. Sits between `readout`/`host_interface` and the VRAM block, replacing direct host access to a second RAM port.

## Interface
- `ADDR_W`, 13, VRAM address width
- `DATA_W`, 8, VRAM data width
- `FIFO_DEPTH`, 4, host request queue depth (power of 2, ≥2)
- `STARVE_LIMIT`, 800, cycles a queued host request may wait before `starve` sets
- `clk`  in  1  VGA dot clock, all logic on rising edge
- `nrst`  in  1  reset, asynchronous, active-low
- `dispReq`  in  1  display needs a RAM read this cycle
- `dispAddr`  in  ADDR_W  display read address
- `dispRdValid`  out  1  pulse: `ramRdData` holds display data
- `hostReq`  in  1  host request valid
- `hostWr`  in  1  1 = write, 0 = read
- `hostAddr`  in  ADDR_W  host address (bank already applied)
- `hostWrData`  in  DATA_W  host write data
- `hostReady`  out  1  queue can accept a request
- `hostRdValid`  out  1  pulse: `hostRdData` valid
- `hostRdData`  out  DATA_W  host read data
- `ramAddr`  out  ADDR_W  registered RAM address
- `ramWrData`  out  DATA_W  registered RAM write data
- `ramWe`  out  1  registered RAM write enable
- `ramRdData`  in  DATA_W  RAM read data, 1 cycle after `ramAddr`
- `starve`  out  1  sticky: a host request exceeded `STARVE_LIMIT`

## Operation
- **Host handshake:** a request is accepted on a rising edge with `hostReq && hostReady`. `{hostWr, hostAddr, hostWrData}` is pushed into the FIFO.
- **`hostReady`:** `hostReady = !full`, computed from the registered count. When full, no push is accepted even if a pop occurs in the same cycle.
- **Grant decision (every cycle):**
  - `dispReq`=1 → GRANT_DISP.
  - Otherwise, FIFO non-empty → GRANT_HOST.
  - Otherwise → GRANT_NONE.
- **Priority:** display always wins. A simultaneous `dispReq` and pending host request yields GRANT_DISP, and the host entry stays queued.
- **GRANT_HOST:** pops the head entry. Writes drive `ramWe`=1 for one cycle. Reads tag the return slot as host.
- **Ordering:** host operations complete strictly in acceptance order, so a read after a write to the same address returns the new data.
- **Read-return pipeline:** a 2-entry shift of `{disp, host}` tags aligns `dispRdValid`/`hostRdValid` with `ramRdData`. `hostRdData` is a registered copy of `ramRdData`, held until the next host read returns.
- **Starve counter:**
  - Counts cycles in which the FIFO is non-empty and no pop occurs.
  - Resets to 0 on each pop.
  - Saturates at `STARVE_LIMIT`; on reaching it, `starve` sets and stays set until reset.
- **Out of scope:** no bank register and no address translation in this block.

## Timing
- **Reset (async assert):** all outputs go to 0; FIFO is empty; tags are cleared; starve counter is 0.
  - `hostReady` rises in the first cycle after `nrst` deasserts.
  - Reset mid-operation discards queued and in-flight requests; no `hostRdValid` follows.
- **Latency:** decision in cycle N → `ramAddr`/`ramWe` at N+1 → `ramRdData` at N+2.
  - `dispRdValid` is high at N+2; the display path therefore has a fixed latency of 2 cycles from `dispReq`.
  - `hostRdValid` is high at N+2 for a host read popped at N.
  - `hostRdData` is valid from N+3 onward (registered copy).
- **Host write:** `ramWe`=1 exactly one cycle, at N+1. `ramAddr`/`ramWrData` are held in that cycle.
- **Throughput:** minimum accept-to-issue time is 1 cycle (push at N, pop at N+1). The FIFO sustains one request per cycle.
- **Empty FIFO:** with `dispReq` low, GRANT_NONE is issued; `ramWe`=0 and `ramAddr` holds its last value.
- **Pointers:** read/write pointers are `log2(FIFO_DEPTH)` bits and wrap modulo depth. Count is `log2(FIFO_DEPTH)+1` bits.

## Structure
- **Shared package `vga_pkg`:**
  - `VRAM_ADDR_W`, `VRAM_DATA_W`.
  - Grant enum {GRANT_NONE, GRANT_DISP, GRANT_HOST}.
  - Host request struct {wr, addr, data}.
  - These are shared with `host_interface` and `readout`.
- **Sub-module `host_req_fifo`:** synchronous FIFO parameterised by width/depth, with push/pop/full/empty/count.
- **`vram_arbiter` itself:** grant logic, output registers, return-tag pipeline, and starve counter.

## Test plan
- **Reset:** hold `nrst`=0 with random inputs → all outputs 0. Release → `hostReady`=1 the next cycle, no valids.
- **Host write/read:** with `dispReq`=0, push write 0x0123←0xA5 at cycle 0, then read 0x0123 at cycle 1.
  - `ramWe`=1 with addr 0x0123 at cycle 2.
  - `hostRdValid` at cycle 4 with `ramRdData`=0xA5; `hostRdData` holds 0xA5 from cycle 5.
- **Display priority:** hold `dispReq`=1 for 80 cycles while 4 host writes are pushed.
  - No `ramWe` during the window; `hostReady`=0 after the 4th push.
  - The 4 writes issue on cycles 1–4 after `dispReq` falls, in order.
  - `dispRdValid` tracks `dispReq` delayed 2 cycles.
- **Full boundary:** fill the FIFO, then assert `hostReq` in the same cycle as a pop → request not accepted; `hostReady` rises the following cycle.
- **Starve:** hold `dispReq`=1 with one queued read for 800 cycles → `starve`=1 at cycle 800 and it stays 1 after the read completes. `nrst` clears it.
- **Reset mid-read:** pulse `nrst` low one cycle after a host read pops → no `hostRdValid`, FIFO empty.
